// File: rtl/kp_midi_pkg.sv
// Shared constants and state types for the MIDI receive path.
// Latency: n/a (package only).
// Backpressure: n/a.
package kp_midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF  = 4'h8;
  localparam logic [3:0] ST_NOTE_ON   = 4'h9;
  localparam logic [3:0] ST_CC        = 4'hB;
  localparam logic [3:0] ST_PITCH     = 4'hE;
  localparam logic [8:0] PITCH_CENTER = 9'h100;

  typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} parser_state_t;

  typedef enum logic [2:0] {
    RX_WAIT_HIGH, RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  function automatic logic is_voice_status(input logic [3:0] hi);
    return (hi == ST_NOTE_OFF) || (hi == ST_NOTE_ON) || (hi == ST_CC) || (hi == ST_PITCH);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: synchroniser, mid-bit sampling, byte and framing-error strobes.
// Latency: byte_vld / frame_err one cycle after the stop-bit sample.
// Backpressure: none; one strobe per frame, consumer must take it.
module midi_uart_rx import kp_midi_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  logic          rx_meta, rx_sync;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          byte_vld_nxt, frame_err_nxt;

  // Synchroniser keeps running through reset so the line level is valid on release.
  always_ff @(posedge clk) begin
    rx_meta <= midi_rx;
    rx_sync <= rx_meta;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_WAIT_HIGH;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      byte_vld  <= byte_vld_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  assign rx_byte = shreg;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    byte_vld_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    unique case (state)
      RX_WAIT_HIGH: if (rx_sync) state_nxt = RX_IDLE;
      RX_IDLE: begin
        cnt_nxt = '0;
        if (!rx_sync) state_nxt = RX_START;
      end
      RX_START: if (cnt == HALF_LAST) begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        state_nxt   = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == BIT_LAST) begin
        cnt_nxt     = '0;
        shreg_nxt   = {rx_sync, shreg[7:1]};
        bit_idx_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_nxt = RX_STOP;
      end
      RX_STOP: if (cnt == BIT_LAST) begin
        cnt_nxt = '0;
        if (rx_sync) begin
          byte_vld_nxt = 1'b1;
          state_nxt    = RX_IDLE;
        end else begin
          // Line is still low: re-arm only after it returns high.
          frame_err_nxt = 1'b1;
          state_nxt     = RX_WAIT_HIGH;
        end
      end
      default: state_nxt = RX_WAIT_HIGH;
    endcase
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice decoder with running status; MIDI_OMNI_EN accepts all channels.
// Latency: outputs/strobes registered one cycle after the final data byte strobe.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
module midi_msg_parser import kp_midi_pkg::*; #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 31250,
  parameter int FILTER_CC = 74
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  input  logic [3:0] channel,
  output logic       note_on,
  output logic       note_off,
  output logic [6:0] note_number,
  output logic [6:0] velocity,
  output logic [8:0] pitch,
  output logic [2:0] filter,
  output logic       frame_err
);

  localparam logic [6:0] FCC = 7'(FILTER_CC);

  logic [7:0]    rx_byte;
  logic          byte_vld;
  logic [6:0]    d2;
  logic          chan_ok;
  parser_state_t state, state_nxt;
  logic [3:0]    run_st, run_st_nxt;
  logic [6:0]    d1, d1_nxt;
  logic          note_on_nxt, note_off_nxt;
  logic [6:0]    note_number_nxt, velocity_nxt;
  logic [8:0]    pitch_nxt;
  logic [2:0]    filter_nxt;

  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .midi_rx   (midi_rx),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  assign d2 = rx_byte[6:0];

`ifdef MIDI_OMNI_EN
  logic unused_channel;
  assign unused_channel = ^channel;
  assign chan_ok = 1'b1;
`else
  assign chan_ok = (rx_byte[3:0] == channel);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= P_IDLE;
      run_st      <= '0;
      d1          <= '0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      note_number <= '0;
      velocity    <= '0;
      pitch       <= PITCH_CENTER;
      filter      <= '0;
    end else begin
      state       <= state_nxt;
      run_st      <= run_st_nxt;
      d1          <= d1_nxt;
      note_on     <= note_on_nxt;
      note_off    <= note_off_nxt;
      note_number <= note_number_nxt;
      velocity    <= velocity_nxt;
      pitch       <= pitch_nxt;
      filter      <= filter_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    run_st_nxt      = run_st;
    d1_nxt          = d1;
    note_on_nxt     = 1'b0;
    note_off_nxt    = 1'b0;
    note_number_nxt = note_number;
    velocity_nxt    = velocity;
    pitch_nxt       = pitch;
    filter_nxt      = filter;
    if (byte_vld) begin
      if (rx_byte[7]) begin
        // Realtime bytes (F8-FF) pass through without disturbing a message in progress.
        if (rx_byte[7:3] != 5'b11111) begin
          if (is_voice_status(rx_byte[7:4]) && chan_ok) begin
            run_st_nxt = rx_byte[7:4];
            state_nxt  = P_DATA1;
          end else begin
            run_st_nxt = '0;
            state_nxt  = P_IDLE;
          end
        end
      end else begin
        unique case (state)
          P_DATA1: begin
            d1_nxt    = d2;
            state_nxt = P_DATA2;
          end
          P_DATA2: begin
            state_nxt = P_DATA1;
            unique case (run_st)
              ST_NOTE_OFF: begin
                note_number_nxt = d1;
                velocity_nxt    = d2;
                note_off_nxt    = 1'b1;
              end
              ST_NOTE_ON: begin
                note_number_nxt = d1;
                velocity_nxt    = d2;
                note_on_nxt     = (d2 != 7'd0);
                note_off_nxt    = (d2 == 7'd0);
              end
              ST_CC: if (d1 == FCC) filter_nxt = d2[6:4];
              ST_PITCH: pitch_nxt = {d2, d1[6:5]};
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: serial byte driver, queue-based message model, per-byte checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_midi_msg_parser;

  localparam int CLK_HZ    = 250_000;
  localparam int BAUD      = 31_250;
  localparam int FILTER_CC = 74;
  localparam int BIT       = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       midi_rx = 1'b1;
  logic [3:0] channel = 4'd0;
  logic       note_on, note_off, frame_err;
  logic [6:0] note_number, velocity;
  logic [8:0] pitch;
  logic [2:0] filter;

  midi_msg_parser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FILTER_CC(FILTER_CC)) dut (
    .clk         (clk),
    .reset       (reset),
    .midi_rx     (midi_rx),
    .channel     (channel),
    .note_on     (note_on),
    .note_off    (note_off),
    .note_number (note_number),
    .velocity    (velocity),
    .pitch       (pitch),
    .filter      (filter),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse counters; a strobe held two cycles counts twice.
  int n_on = 0, n_off = 0, n_fe = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (note_on)   n_on++;
      if (note_off)  n_off++;
      if (frame_err) n_fe++;
    end
  end

  // Reference model: running status byte plus a queue of pending data bytes.
  int       m_run;
  int       m_data[$];
  int       m_nn, m_vel, m_pitch, m_filt;
  int       e_on, e_off, e_fe;

  task automatic model_reset();
    m_run = -1;
    m_data.delete();
    m_nn = 0; m_vel = 0; m_pitch = 256; m_filt = 0;
  endtask

  task automatic model_byte(input int b);
    int hi, d1, d2;
    bit ch_ok;
    e_on = 0; e_off = 0; e_fe = 0;
    if (b >= 'hF8) return;
    if (b >= 'h80) begin
      hi = b / 16;
`ifdef MIDI_OMNI_EN
      ch_ok = 1'b1;
`else
      ch_ok = ((b % 16) == int'(channel));
`endif
      if ((hi == 8 || hi == 9 || hi == 11 || hi == 14) && ch_ok) m_run = b;
      else m_run = -1;
      m_data.delete();
      return;
    end
    if (m_run < 0) return;
    m_data.push_back(b);
    if (m_data.size() == 2) begin
      d1 = m_data[0];
      d2 = m_data[1];
      m_data.delete();
      case (m_run / 16)
        8:  begin m_nn = d1; m_vel = d2; e_off = 1; end
        9:  begin m_nn = d1; m_vel = d2; if (d2 > 0) e_on = 1; else e_off = 1; end
        11: if (d1 == FILTER_CC) m_filt = d2 / 16;
        14: m_pitch = d2 * 4 + d1 / 32;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] obs_out();
    return {6'd0, note_number, velocity, pitch, filter};
  endfunction

  function automatic logic [31:0] exp_out();
    return {6'd0, 7'(m_nn), 7'(m_vel), 9'(m_pitch), 3'(m_filt)};
  endfunction

  task automatic send(input logic [7:0] b, input bit stop_hi);
    int s_on, s_off, s_fe;
    s_on = n_on; s_off = n_off; s_fe = n_fe;
    midi_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    midi_rx = stop_hi;
    repeat (BIT) @(negedge clk);
    midi_rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    if (stop_hi) model_byte(int'(b));
    else begin e_on = 0; e_off = 0; e_fe = 1; end
    check($sformatf("events_%02h", b),
          32'(((n_on - s_on) << 16) | ((n_off - s_off) << 8) | (n_fe - s_fe)),
          32'((e_on << 16) | (e_off << 8) | e_fe));
    check($sformatf("outputs_%02h", b), obs_out(), exp_out());
  endtask

  initial begin
    int s_on, s_off, s_fe, r;
    logic [7:0] b;
    logic [3:0] ty;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("reset_strobes", {29'd0, note_on, note_off, frame_err}, 32'd0);
    check("reset_outputs", obs_out(), {6'd0, 7'd0, 7'd0, 9'h100, 3'd0});

    send(8'h90, 1); send(8'h3C, 1); send(8'h64, 1);
    check("first_note", {16'd0, 1'b0, note_number, 1'b0, velocity}, {16'd0, 8'h3C, 8'h64});
    send(8'h90, 1); send(8'h40, 1); send(8'h50, 1);
    send(8'h40, 1); send(8'h00, 1);
    send(8'h91, 1); send(8'h3C, 1); send(8'h64, 1);
    send(8'hE0, 1); send(8'h7F, 1); send(8'h7F, 1);
    check("pitch_max", {23'd0, pitch}, 32'h1FF);
    send(8'hE0, 1); send(8'h00, 1); send(8'h40, 1);
    check("pitch_centre", {23'd0, pitch}, 32'h100);
    send(8'hB0, 1); send(8'h4A, 1); send(8'h7F, 1);
    send(8'hB0, 1); send(8'h07, 1); send(8'h00, 1);
    check("filter_kept", {29'd0, filter}, 32'd7);
    send(8'h90, 1); send(8'h3C, 1); send(8'hF8, 1); send(8'h64, 1);
    send(8'h5A, 0);

    // Reset while the line is low mid-frame; the low line must not start a frame afterwards.
    s_on = n_on; s_off = n_off; s_fe = n_fe;
    midi_rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (12 * BIT) @(negedge clk);
    midi_rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("midreset_events", 32'((n_on - s_on) + (n_off - s_off) + (n_fe - s_fe)), 32'd0);
    check("midreset_outputs", obs_out(), {6'd0, 7'd0, 7'd0, 9'h100, 3'd0});
    send(8'h3C, 1); send(8'h64, 1);

    for (int k = 0; k < 160; k++) begin
      if ($urandom_range(0, 29) == 0) channel = 4'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          case ($urandom_range(0, 3))
            0: ty = 4'h8;
            1: ty = 4'h9;
            2: ty = 4'hB;
            default: ty = 4'hE;
          endcase
          b = {ty, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : channel};
        end
        2: b = 8'($urandom_range('hF8, 'hFF));
        3: b = 8'($urandom_range('h80, 'hF7));
        4: b = 8'h4A;
        5: b = 8'h00;
        default: b = 8'($urandom_range(0, 127));
      endcase
      send(b, ($urandom_range(0, 24) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
